udc_trend_monitor: RTL and testbench
====================================

UDC_TREND_MONITOR -- requirements
Module: udc_trend_monitor

Interface
REQ-001 SHALL have parameter: DEPTH, 4, turnaround-event FIFO depth (power of two, 2..16).
REQ-002 SHALL have port: clock  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: areset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: data_in  input  8  counter sample from upstream up/down counter.
REQ-005 SHALL have port: data_valid  input  1  data_in is a new sample this cycle.
REQ-006 SHALL have port: dir  output  2  trend: 0 unknown, 1 up, 2 down.
REQ-007 SHALL have port: turn_valid  output  1  FIFO non-empty, head event presented.
REQ-008 SHALL have port: turn_kind  output  1  head event kind: 0 peak, 1 trough.
REQ-009 SHALL have port: turn_data  output  8  head event value.
REQ-010 SHALL have port: turn_ready  input  1  consumer accepts head event.
REQ-011 SHALL have port: fifo_level  output  $clog2(DEPTH+1)  occupied entries.
REQ-012 SHALL have port: overflow  output  1  sticky, an event was dropped.
REQ-013 SHALL have port: min_val / max_val  output  8 each  running extrema.

Function
REQ-014 SHALL run FSM states IDLE, PRIMED, UP, DOWN, advancing only on data_valid.
REQ-015 SHALL compute delta = (data_in - prev) mod 256; delta 0 = hold, delta[7]=0 = rising, delta[7]=1 = falling (delta 128 falls).
REQ-016 SHALL move IDLE->PRIMED on the first sample, storing it as prev.
REQ-017 SHALL move PRIMED->UP on rising, PRIMED->DOWN on falling, and stay in PRIMED on hold.
REQ-018 SHALL push {peak, prev} and move UP->DOWN on falling; SHALL push {trough, prev} and move DOWN->UP on rising.
REQ-019 SHALL leave state unchanged and push nothing on a hold sample; prev stays equal.
REQ-020 SHALL treat wrap 255->0 as rising and 0->255 as falling, with no turnaround unless direction reverses.
REQ-021 SHALL update prev on every data_valid.
REQ-022 SHALL register dir, reflecting the state after the sample (IDLE/PRIMED = 0).
REQ-023 SHALL make a pushed event visible on turn_valid the cycle after the reversing sample.
REQ-024 SHALL pop on turn_valid && turn_ready; turn_kind/turn_data SHALL hold stable while turn_valid && !turn_ready.
REQ-025 SHALL complete a simultaneous push and pop with full FIFO, with no drop and level unchanged.
REQ-026 SHALL discard a push into a full FIFO without a simultaneous pop, set overflow, and leave contents intact.
REQ-027 SHALL ignore turn_ready when the FIFO is empty.

Reset
REQ-028 SHALL, on areset high at a clock edge, set state IDLE, dir 0, prev 0, FIFO empty, fifo_level 0, turn_valid 0, turn_kind 0, turn_data 0, overflow 0, min_val 8'hFF, max_val 8'h00.
REQ-029 SHALL let areset win over data_valid and turn_ready in the same cycle, with no event pushed or popped.
REQ-030 SHALL discard all queued events on mid-operation reset.

Configuration
REQ-031 SHALL, with UDC_MON_STATS_EN defined, update min_val/max_val on every data_valid (registered, visible next cycle).
REQ-032 SHALL, with UDC_MON_STATS_EN undefined, omit the extrema logic and drive min_val/max_val constant 0; ports remain.

Structure
REQ-033 SHALL take from package udc_mon_pkg: DATA_W=8, state enum, event-kind enum, event struct {kind, value}.
REQ-034 SHALL place the FIFO in sub-module udc_mon_fifo (parameter DEPTH, push/pop/full/empty/level).

Verification
REQ-035 SHALL check: samples 10,11,12,11 -> dir 1 then 2; one event {peak,12}; turn_valid next cycle.
REQ-036 SHALL check: samples 254,255,0,1 -> dir stays 1; no event.
REQ-037 SHALL check: samples 5,5,5,6 -> PRIMED held through repeats; dir 1 after 6; no event.
REQ-038 SHALL check: DEPTH=4, turn_ready=0, zig-zag 1,3,1,3,1,3,1 -> level 4, overflow 1, head {peak,3}.
REQ-039 SHALL check: full FIFO with turn_ready=1 and a reversing sample in the same cycle -> level stays 4, overflow stays 0.
REQ-040 SHALL check: areset mid-stream with level 2 -> next cycle level 0, dir 0, min_val FF, max_val 00 (stats build).

Source files
------------

// File: rtl/udc_mon_pkg.sv
// Shared types for the up/down-counter trend monitor.
//   DATA_W        : sample width
//   state_t       : trend FSM states
//   ev_kind_t     : turnaround event kind (peak / trough)
//   turn_event_t  : queued turnaround event {kind, value}
package udc_mon_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIMED = 2'd1,
    ST_UP     = 2'd2,
    ST_DOWN   = 2'd3
  } state_t;

  typedef enum logic {
    EV_PEAK   = 1'b0,
    EV_TROUGH = 1'b1
  } ev_kind_t;

  typedef struct packed {
    ev_kind_t             kind;
    logic [DATA_W-1:0]    value;
  } turn_event_t;

  localparam logic [1:0] DIR_UNKNOWN = 2'd0;
  localparam logic [1:0] DIR_UP      = 2'd1;
  localparam logic [1:0] DIR_DOWN    = 2'd2;

endpackage

// File: rtl/udc_mon_fifo.sv
// Turnaround-event FIFO for udc_trend_monitor.
// Ports:
//   clock, areset   : clock and synchronous active-high reset
//   push, push_data : write request and packed event {kind, value}
//   pop             : read request (ignored while empty)
//   head            : oldest entry, zero while empty
//   full, empty     : occupancy flags
//   level           : number of occupied entries
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is dropped and the stored contents are untouched.
module udc_mon_fifo
  import udc_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         areset,
  input  logic                         push,
  input  logic [DATA_W:0]              push_data,
  input  logic                         pop,
  output logic [DATA_W:0]              head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (areset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LW'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/udc_trend_monitor.sv
// Trend monitor for an up/down counter sample stream.
// Tracks rising/falling trend of data_in and queues a peak or trough event
// whenever the trend reverses. Optional running min/max statistics are built
// only when UDC_MON_STATS_EN is defined; otherwise min_val/max_val read 0.
// Ports:
//   clock, areset          : clock and synchronous active-high reset
//   data_in, data_valid    : sample input
//   dir                    : 0 unknown, 1 up, 2 down (registered)
//   turn_valid/kind/data   : head of event FIFO, turn_ready pops it
//   fifo_level             : occupied FIFO entries
//   overflow               : sticky, an event was dropped
//   min_val, max_val       : running extrema
//
// state     | meaning
// ST_IDLE   | no sample seen since reset
// ST_PRIMED | reference sample held, no change seen yet
// ST_UP     | last non-zero change was rising
// ST_DOWN   | last non-zero change was falling
module udc_trend_monitor
  import udc_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         areset,
  input  logic [7:0]                   data_in,
  input  logic                         data_valid,
  output logic [1:0]                   dir,
  output logic                         turn_valid,
  output logic                         turn_kind,
  output logic [7:0]                   turn_data,
  input  logic                         turn_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow,
  output logic [7:0]                   min_val,
  output logic [7:0]                   max_val
);

  state_t            state;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] delta;
  logic              rising;
  logic              falling;
  logic              push;
  turn_event_t       push_ev;
  logic [DATA_W:0]   head;
  logic              full;
  logic              empty;

  // Modular difference: 255->0 reads as +1, 0->255 as -1, 128 counts as falling.
  assign delta   = data_in - prev;
  assign rising  = (delta != '0) && !delta[DATA_W-1];
  assign falling = delta[DATA_W-1];

  always_comb begin
    push          = 1'b0;
    push_ev.kind  = EV_PEAK;
    push_ev.value = prev;
    if (data_valid) begin
      if (state == ST_UP && falling) begin
        push = 1'b1;
      end else if (state == ST_DOWN && rising) begin
        push         = 1'b1;
        push_ev.kind = EV_TROUGH;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (areset) begin
      state    <= ST_IDLE;
      dir      <= DIR_UNKNOWN;
      prev     <= '0;
      overflow <= 1'b0;
    end else begin
      // Full implies non-empty, so a ready consumer always frees a slot.
      if (push && full && !turn_ready) begin
        overflow <= 1'b1;
      end
      if (data_valid) begin
        prev <= data_in;
        case (state)
          ST_IDLE: begin
            state <= ST_PRIMED;
            dir   <= DIR_UNKNOWN;
          end
          ST_PRIMED: begin
            if (rising) begin
              state <= ST_UP;
              dir   <= DIR_UP;
            end else if (falling) begin
              state <= ST_DOWN;
              dir   <= DIR_DOWN;
            end
          end
          ST_UP: begin
            if (falling) begin
              state <= ST_DOWN;
              dir   <= DIR_DOWN;
            end
          end
          ST_DOWN: begin
            if (rising) begin
              state <= ST_UP;
              dir   <= DIR_UP;
            end
          end
          default: begin
            state <= ST_IDLE;
            dir   <= DIR_UNKNOWN;
          end
        endcase
      end
    end
  end

  udc_mon_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .areset    (areset),
    .push      (push),
    .push_data (push_ev),
    .pop       (turn_ready),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign turn_valid = !empty;
  assign turn_kind  = head[DATA_W];
  assign turn_data  = head[DATA_W-1:0];

`ifdef UDC_MON_STATS_EN
  always_ff @(posedge clock) begin
    if (areset) begin
      min_val <= 8'hFF;
      max_val <= 8'h00;
    end else if (data_valid) begin
      if (data_in < min_val) min_val <= data_in;
      if (data_in > max_val) max_val <= data_in;
    end
  end
`else
  assign min_val = 8'h00;
  assign max_val = 8'h00;
`endif

endmodule

// File: tb/tb_udc_trend_monitor.sv
module tb_udc_trend_monitor;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       areset;
  logic [7:0] data_in;
  logic       data_valid;
  logic [1:0] dir;
  logic       turn_valid;
  logic       turn_kind;
  logic [7:0] turn_data;
  logic       turn_ready;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [7:0] min_val;
  logic [7:0] max_val;

  udc_trend_monitor #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .areset     (areset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .dir        (dir),
    .turn_valid (turn_valid),
    .turn_kind  (turn_kind),
    .turn_data  (turn_data),
    .turn_ready (turn_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .min_val    (min_val),
    .max_val    (max_val)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: trend = direction of the most recent non-zero change;
  // an event is queued each time that direction flips.
  bit         m_seen;
  int         m_prev;
  int         m_dir;
  logic [8:0] m_q[$];
  bit         m_ovf;
  int         m_min;
  int         m_max;

  task automatic model_reset();
    m_seen = 0; m_prev = 0; m_dir = 0; m_q.delete(); m_ovf = 0;
    m_min = 255; m_max = 0;
  endtask

  task automatic model_cycle(input bit v, input int d, input bit r, input bit rst);
    int  diff;
    bit  have_ev;
    logic [8:0] ev;
    if (rst) begin
      model_reset();
      return;
    end
    have_ev = 0;
    ev = '0;
    if (v) begin
      if (m_seen) begin
        diff = (d - m_prev + 256) % 256;
        if (diff != 0) begin
          if (diff < 128) begin
            if (m_dir == 2) begin have_ev = 1; ev = {1'b1, 8'(m_prev)}; end
            m_dir = 1;
          end else begin
            if (m_dir == 1) begin have_ev = 1; ev = {1'b0, 8'(m_prev)}; end
            m_dir = 2;
          end
        end
      end
      m_seen = 1;
      m_prev = d;
      if (d < m_min) m_min = d;
      if (d > m_max) m_max = d;
    end
    if (r && m_q.size() > 0) void'(m_q.pop_front());
    if (have_ev) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    check_val("dir", dir, m_dir);
    check_val("turn_valid", turn_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check_val("turn_kind", turn_kind, m_q[0][8]);
      check_val("turn_data", turn_data, m_q[0][7:0]);
    end
    check_val("fifo_level", fifo_level, m_q.size());
    check_val("overflow", overflow, m_ovf);
`ifdef UDC_MON_STATS_EN
    check_val("min_val", min_val, m_min);
    check_val("max_val", max_val, m_max);
`else
    check_val("min_val", min_val, 0);
    check_val("max_val", max_val, 0);
`endif
  endtask

  task automatic step(input bit v, input int d, input bit r, input bit rst);
    data_valid = v; data_in = 8'(d); turn_ready = r; areset = rst;
    @(posedge clock);
    model_cycle(v, d, r, rst);
    #1;
    compare_all();
  endtask

  task automatic samples(input int s[], input bit r);
    foreach (s[i]) step(1, s[i], r, 0);
  endtask

  initial begin
    int cur;
    bit v, r, rst;
    int d;
    model_reset();
    areset = 1; data_valid = 0; data_in = 0; turn_ready = 0;
    step(1, 77, 1, 1);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_dir", dir, 0);

    // Simple peak: 10,11,12,11
    samples('{10, 11, 12}, 0);
    check_val("peak_pre_tv", turn_valid, 0);
    check_val("peak_dir_up", dir, 1);
    step(1, 11, 0, 0);
    check_val("peak_dir_dn", dir, 2);
    check_val("peak_tv", turn_valid, 1);
    check_val("peak_kind", turn_kind, 0);
    check_val("peak_data", turn_data, 12);
    check_val("peak_level", fifo_level, 1);

    // Wrap 254,255,0,1 stays rising
    step(0, 0, 0, 1);
    samples('{254, 255, 0, 1}, 0);
    check_val("wrap_dir", dir, 1);
    check_val("wrap_level", fifo_level, 0);

    // Repeats hold PRIMED
    step(0, 0, 0, 1);
    samples('{5, 5, 5}, 0);
    check_val("hold_dir", dir, 0);
    step(1, 6, 0, 0);
    check_val("hold_dir_up", dir, 1);
    check_val("hold_level", fifo_level, 0);

    // Overflow with zig-zag
    step(0, 0, 0, 1);
    samples('{1, 3, 1, 3, 1, 3, 1}, 0);
    check_val("ovf_level", fifo_level, 4);
    check_val("ovf_flag", overflow, 1);
    check_val("ovf_head_kind", turn_kind, 0);
    check_val("ovf_head_data", turn_data, 3);
    // Head stays put while not accepted
    step(0, 0, 0, 0);
    check_val("ovf_head_stable", turn_data, 3);

    // Full FIFO with simultaneous push and pop
    step(0, 0, 0, 1);
    samples('{1, 3, 1, 3, 1, 3}, 0);
    check_val("full_level", fifo_level, 4);
    step(1, 1, 1, 0);
    check_val("full_pp_level", fifo_level, 4);
    check_val("full_pp_ovf", overflow, 0);

    // Mid-stream reset with level 2
    step(0, 0, 0, 1);
    samples('{1, 3, 1, 3}, 0);
    check_val("mid_level2", fifo_level, 2);
    step(1, 9, 1, 1);
    check_val("mid_rst_level", fifo_level, 0);
    check_val("mid_rst_dir", dir, 0);
`ifdef UDC_MON_STATS_EN
    check_val("mid_rst_min", min_val, 8'hFF);
    check_val("mid_rst_max", max_val, 8'h00);
`endif

    // Randomized traffic against the model
    cur = 100;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 255);
      else d = (cur + $urandom_range(0, 6) - 3 + 256) % 256;
      if (v) cur = d;
      r = ($urandom_range(0, 2) == 0);
      step(v, d, r, rst);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
